// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: FSM states, error codes and index sizing shared by the memory bus fabric.
package mem_bus_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_DONE = 2'd2;
   typedef logic [1:0] err_t;
   localparam err_t ERR_NONE    = 2'd0;
   localparam err_t ERR_MISS    = 2'd1;
   localparam err_t ERR_TIMEOUT = 2'd2;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mem_bus_decode.sv
// mem_bus_decode: base/mask address matcher; the lowest matching slave index wins.
module mem_bus_decode
   import mem_bus_pkg::*;
#(
   parameter int              N    = 4,
   parameter logic [N*32-1:0] BASE = {N{32'h0}},
   parameter logic [N*32-1:0] MASK = {N{32'hFFFF_FFFF}},
   parameter int              IW   = idx_w(N)
) (
   input  logic [31:0]   addr,
   output logic          hit,
   output logic [IW-1:0] idx
);
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if ((addr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
            hit = 1'b1;
            idx = IW'(i);
         end
   end
endmodule

// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric: picorv32 native port to N slaves with registered response, timeout and decode-miss errors.
// Define MEMBUS_ERRLOG_EN to add the internal error-log window at ERRLOG_BASE.
module mem_bus_fabric
   import mem_bus_pkg::*;
#(
   parameter int                     N_SLAVES       = 4,
   parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {N_SLAVES{32'h0}},
   parameter logic [N_SLAVES*32-1:0] SLAVE_MASK     = {N_SLAVES{32'hFFFF_FFFF}},
   parameter int                     TIMEOUT_CYCLES = 255,
   parameter logic [31:0]            ERR_RDATA      = 32'hFFFF_FFFF,
   parameter logic [31:0]            ERRLOG_BASE    = 32'h0F00_0000
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [31:0]              mem_addr,
   input  logic [31:0]              mem_wdata,
   input  logic [3:0]               mem_wstrb,
   output logic [31:0]              mem_rdata,
   output logic [N_SLAVES-1:0]      s_valid,
   input  logic [N_SLAVES-1:0]      s_ready,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic [4*N_SLAVES-1:0]    s_wstrb,
   input  logic [32*N_SLAVES-1:0]   s_rdata,
   output logic                     err_irq
);
   localparam int IW = idx_w(N_SLAVES);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   state_t        state_q, state_d;
   logic [IW-1:0] sel_q, sel_d, dec_idx;
   logic          dec_hit;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   err_t          err_q, err_d;
   mem_bus_decode #(.N(N_SLAVES), .BASE(SLAVE_BASE), .MASK(SLAVE_MASK), .IW(IW)) u_decode (
      .addr(mem_addr),
      .hit (dec_hit),
      .idx (dec_idx)
   );
`ifdef MEMBUS_ERRLOG_EN
   logic [31:0] laddr_q, laddr_d;
   logic        lto_q, lto_d, lmiss_q, lmiss_d;
   logic [15:0] lcnt_q, lcnt_d;
   logic        log_hit;
   assign log_hit = (mem_addr & ~32'h7) == ERRLOG_BASE;
`else
   logic unused_errlog;
   assign unused_errlog = ^ERRLOG_BASE;
`endif
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: if (mem_valid) begin
            cnt_d = '0;
            err_d = ERR_NONE;
            if (dec_hit) begin
               sel_d   = dec_idx;
               state_d = ST_BUSY;
            end else begin
               rdata_d = ERR_RDATA;
               err_d   = ERR_MISS;
               state_d = ST_DONE;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (!mem_valid)
               state_d = ST_IDLE;
            else if (s_ready[sel_q]) begin
               rdata_d = s_rdata[32*sel_q +: 32];
               state_d = ST_DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = ERR_RDATA;
               err_d   = ERR_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef MEMBUS_ERRLOG_EN
      laddr_d = laddr_q;
      lto_d   = lto_q;
      lmiss_d = lmiss_q;
      lcnt_d  = lcnt_q;
      // log window overrides the table decode and never raises an error itself
      if (state_q == ST_IDLE && mem_valid && log_hit) begin
         state_d = ST_DONE;
         err_d   = ERR_NONE;
         sel_d   = sel_q;
         rdata_d = mem_addr[2] ? {14'b0, lto_q, lmiss_q, lcnt_q} : laddr_q;
         if (mem_addr[2] && |mem_wstrb) begin
            lcnt_d  = '0;
            lto_d   = 1'b0;
            lmiss_d = 1'b0;
         end
      end
      if (state_q != ST_DONE && state_d == ST_DONE && err_d != ERR_NONE) begin
         laddr_d = mem_addr;
         lto_d   = err_d == ERR_TIMEOUT;
         lmiss_d = err_d == ERR_MISS;
         lcnt_d  = lcnt_q + {15'b0, ~&lcnt_q};
      end
`endif
   end
   always_comb begin
      s_valid = '0;
      s_wstrb = '0;
      if (state_q == ST_BUSY) begin
         s_valid[sel_q]         = mem_valid;
         s_wstrb[4*sel_q +: 4] = mem_wstrb;
      end
   end
   assign s_addr    = mem_addr;
   assign s_wdata   = mem_wdata;
   assign mem_ready = state_q == ST_DONE;
   assign mem_rdata = rdata_q;
   assign err_irq   = mem_ready && err_q != ERR_NONE;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= ERR_NONE;
`ifdef MEMBUS_ERRLOG_EN
         laddr_q <= '0;
         lto_q   <= 1'b0;
         lmiss_q <= 1'b0;
         lcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef MEMBUS_ERRLOG_EN
         laddr_q <= laddr_d;
         lto_q   <= lto_d;
         lmiss_q <= lmiss_d;
         lcnt_q  <= lcnt_d;
`endif
      end
endmodule

// File: tb/tb_mem_bus_fabric.sv
// tb_mem_bus_fabric: directed transactions with a response scoreboard checked by an independent monitor.
module tb_mem_bus_fabric;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_rdata;
   logic [1:0]  s_valid;
   logic [1:0]  s_ready = '0;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [7:0]  s_wstrb;
   logic [63:0] s_rdata = '0;
   logic        err_irq;
   int          errors = 0;
   int          checks = 0;
   logic [32:0] sb[$];
   logic [32:0] exp_e;

   mem_bus_fabric #(
      .N_SLAVES      (2),
      .SLAVE_BASE    ({32'h0300_0000, 32'h0000_0000}),
      .SLAVE_MASK    ({32'hFF00_0000, 32'hFFFF_C000}),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .mem_valid(mem_valid),
      .mem_ready(mem_ready),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wstrb  (s_wstrb),
      .s_rdata  (s_rdata),
      .err_irq  (err_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got mem_ready=1 expected no pending response");
         end else begin
            exp_e = sb.pop_front();
            chk("rdata", mem_rdata, exp_e[32:1]);
            chk("err_irq", {31'b0, err_irq}, {31'b0, exp_e[0]});
         end
      end else if (err_irq) begin
         checks++;
         errors++;
         $display("FAIL stray_irq: got err_irq=1 expected 0 outside mem_ready");
      end
   end

   // dly: number of s_valid cycles before the target slave raises s_ready (-1 = never)
   task automatic xact(input string n, input logic [31:0] a, input logic [3:0] ws, input int sl,
                       input int dly, input logic [31:0] rd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input int exp_sv, input logic [7:0] exp_ws);
      int cyc, svc, sva, lat;
      logic [7:0] wsacc;
      @(negedge clk);
      s_rdata = {2{32'h5555_AAAA}};
      s_rdata[32*sl +: 32] = rd;
      mem_addr  = a;
      mem_wdata = ~a;
      mem_wstrb = ws;
      mem_valid = 1'b1;
      sb.push_back({exp_rd, exp_err});
      cyc = 1; svc = 0; sva = 0; lat = 0; wsacc = '0;
      while (lat == 0 && cyc < 40) begin
         #1;
         if (cyc == 1) begin
            chk({n, "_saddr"}, s_addr, a);
            chk({n, "_swdata"}, s_wdata, ~a);
         end
         if (mem_ready) lat = cyc;
         if (|s_valid) sva++;
         if (s_valid[sl]) svc++;
         wsacc |= s_wstrb;
         s_ready = '0;
         s_ready[1-sl] = 1'b1;
         if (s_valid[sl] && dly >= 0 && svc == dly + 1) s_ready[sl] = 1'b1;
         if (lat == 0) begin
            @(negedge clk);
            cyc++;
         end
      end
      mem_valid = 1'b0;
      s_ready   = '0;
      chk({n, "_latency"}, lat, exp_lat);
      chk({n, "_sel_valid_cycles"}, svc, exp_sv);
      chk({n, "_any_valid_cycles"}, sva, exp_sv);
      chk({n, "_wstrb"}, {24'b0, wsacc}, {24'b0, exp_ws});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected $finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, mem_ready}, 0);
      chk("rst_rdata", mem_rdata, 0);
      chk("rst_svalid", {30'b0, s_valid}, 0);
      chk("rst_swstrb", {24'b0, s_wstrb}, 0);
      chk("rst_irq", {31'b0, err_irq}, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      xact("rd_s0", 32'h0000_0010, 4'b0000, 0, 2, 32'h1234_5678, 32'h1234_5678, 1'b0, 5, 3, 8'h00);
      repeat (3) @(negedge clk);
      chk("rdata_hold", mem_rdata, 32'h1234_5678);
      xact("wr_s1", 32'h0300_0004, 4'b0011, 1, 0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 3, 1, 8'h30);
      xact("timeout_s1", 32'h0300_0000, 4'b0000, 1, -1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 10, 8, 8'h00);
`ifdef MEMBUS_ERRLOG_EN
      xact("log_addr", 32'h0F00_0000, 4'b0000, 0, -1, 32'h0, 32'h0300_0000, 1'b0, 2, 0, 8'h00);
      xact("log_stat", 32'h0F00_0004, 4'b0000, 0, -1, 32'h0, 32'h0002_0001, 1'b0, 2, 0, 8'h00);
`else
      xact("log_miss", 32'h0F00_0000, 4'b0000, 0, -1, 32'h0, 32'hFFFF_FFFF, 1'b1, 2, 0, 8'h00);
`endif
      xact("miss", 32'h0500_0000, 4'b0000, 0, -1, 32'h0, 32'hFFFF_FFFF, 1'b1, 2, 0, 8'h00);
      xact("ready_at_7", 32'h0300_0100, 4'b0000, 1, 7, 32'h7777_0007, 32'h7777_0007, 1'b0, 10, 8, 8'h00);
      xact("edge_s0_top", 32'h0000_3FFC, 4'b1111, 0, 0, 32'h0000_3FFC, 32'h0000_3FFC, 1'b0, 3, 1, 8'h0F);
      xact("edge_s0_out", 32'h0000_4000, 4'b0000, 0, -1, 32'h0, 32'hFFFF_FFFF, 1'b1, 2, 0, 8'h00);
      xact("edge_s1_top", 32'h03FF_FFFC, 4'b1000, 1, 1, 32'hA1A1_A1A1, 32'hA1A1_A1A1, 1'b0, 4, 2, 8'h80);
      @(negedge clk);
      mem_addr  = 32'h0300_0008;
      mem_wstrb = 4'b0000;
      mem_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("busy_svalid", {30'b0, s_valid}, 32'h2);
      #2 resetn = 1'b0;
      #1;
      chk("arst_svalid", {30'b0, s_valid}, 0);
      chk("arst_ready", {31'b0, mem_ready}, 0);
      chk("arst_rdata", mem_rdata, 0);
      @(negedge clk);
      mem_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      xact("post_rst", 32'h0300_0010, 4'b0000, 1, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 4, 2, 8'h00);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
